// File: rtl/rom_y_reader_pkg.sv
// Shared ROM_Y geometry and reader FSM encoding.
// Imported by rom_y_reader and by anything else that talks to ROM_Y.
package rom_y_reader_pkg;

   localparam int ROM_ADDR_WIDTH = 6;
   localparam int ROM_DATA_WIDTH = 16;
   localparam int ROM_MEM_SIZE   = 64;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } rd_state_e;

   // Next word address, wrapping at the end of the ROM even if it is not a power of two.
   function automatic logic [ROM_ADDR_WIDTH-1:0] next_addr(input logic [ROM_ADDR_WIDTH-1:0] a);
      return (a == ROM_ADDR_WIDTH'(ROM_MEM_SIZE - 1)) ? '0 : a + ROM_ADDR_WIDTH'(1);
   endfunction

endpackage

// File: rtl/rom_rd_fifo.sv
// Synchronous output FIFO with registered head word (first word visible the cycle after its write).
// Simultaneous push and pop on a full buffer is legal and keeps occupancy.
module rom_rd_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 16
) (
   input  logic                     CK,
   input  logic                     RST_N,
   input  logic                     push,
   input  logic [WIDTH-1:0]         wdata,
   input  logic                     pop,
   output logic [WIDTH-1:0]         rdata,
   output logic                     valid,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic [PW-1:0]    rd_ptr_d;
   logic [PW:0]      count_d;
   logic [PW:0]      remain;
   logic             do_push;
   logic             do_pop;

   // NOTE: every signal assigned in always_comb gets a value first, so no latch can be inferred.
   always_comb begin
      do_pop   = pop && valid;
      do_push  = push && ((count != (PW+1)'(DEPTH)) || do_pop);
      remain   = count - (PW+1)'(do_pop);
      count_d  = remain + (PW+1)'(do_push);
      rd_ptr_d = do_pop ? rd_ptr + PW'(1) : rd_ptr;
   end

   // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
   always_ff @(posedge CK or negedge RST_N) begin
      if (!RST_N) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         valid  <= 1'b0;
         rdata  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PW'(1);
         rd_ptr <= rd_ptr_d;
         count  <= count_d;
         valid  <= (count_d != '0);
         // An empty-after-pop buffer takes the incoming word straight into the head register.
         if (do_push && (remain == '0)) rdata <= wdata;
         else if (count_d != '0)        rdata <= mem[rd_ptr_d];
      end
   end

   // NOTE: storage is not reset; valid/count guard every read, so its power-up contents never escape.
   always_ff @(posedge CK) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/rom_y_reader.sv
// Burst reader: streams len words from ROM_Y starting at base_addr onto a valid/ready port.
// Optional macro ROM_Y_RD_STALL_CNT_EN enables the saturating backpressure counter stall_cnt.
module rom_y_reader
   import rom_y_reader_pkg::*;
#(
   parameter int FIFO_DEPTH = 4
) (
   input  logic                      CK,
   input  logic                      RST_N,
   input  logic                      start,
   input  logic [ROM_ADDR_WIDTH-1:0] base_addr,
   input  logic [ROM_ADDR_WIDTH:0]   len,
   output logic                      busy,
   output logic                      done,
   output logic [ROM_ADDR_WIDTH-1:0] rom_a,
   output logic                      rom_oe,
   input  logic [ROM_DATA_WIDTH-1:0] rom_q,
   output logic [ROM_DATA_WIDTH-1:0] y_data,
   output logic                      y_valid,
   input  logic                      y_ready,
   output logic                      y_last,
   output logic [15:0]               stall_cnt
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   rd_state_e                 state_q, state_d;
   logic [ROM_ADDR_WIDTH-1:0] addr_q;
   logic [ROM_ADDR_WIDTH:0]   issue_left_q;
   logic [ROM_ADDR_WIDTH:0]   out_left_q;
   logic                      pend_q;
   logic [CW-1:0]             fifo_count;
   logic [CW:0]               occupancy;
   logic                      accept;
   logic                      issue;
   logic                      xfer;
   logic                      last_xfer;

   // Words buffered plus reads still travelling through the ROM pipeline.
   assign occupancy = (CW+1)'(fifo_count) + (CW+1)'(pend_q) + (CW+1)'(rom_oe);
   assign xfer      = y_valid && y_ready;
   assign busy      = (state_q != ST_IDLE);
   assign y_last    = y_valid && (out_left_q == (ROM_ADDR_WIDTH+1)'(1));

   always_ff @(posedge CK or negedge RST_N) begin
      if (!RST_N) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d   = state_q;
      accept    = 1'b0;
      issue     = 1'b0;
      last_xfer = 1'b0;
      case (state_q)
         ST_IDLE: begin
            accept = start;
            if (start && (len != '0)) state_d = ST_RUN;
         end
         ST_RUN: begin
            issue = (occupancy < (CW+1)'(FIFO_DEPTH));
            if (issue && (issue_left_q == (ROM_ADDR_WIDTH+1)'(1))) state_d = ST_DRAIN;
         end
         ST_DRAIN: begin
            last_xfer = xfer && (out_left_q == (ROM_ADDR_WIDTH+1)'(1));
            if (last_xfer) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge CK or negedge RST_N) begin
      if (!RST_N) begin
         addr_q       <= '0;
         issue_left_q <= '0;
         out_left_q   <= '0;
         rom_a        <= '0;
         pend_q       <= 1'b0;
         rom_oe       <= 1'b0;
         done         <= 1'b0;
      end else begin
         if (accept && (len != '0)) begin
            addr_q       <= base_addr;
            issue_left_q <= len;
            out_left_q   <= len;
         end
         if (issue) begin
            rom_a        <= addr_q;
            addr_q       <= next_addr(addr_q);
            issue_left_q <= issue_left_q - (ROM_ADDR_WIDTH+1)'(1);
         end
         if (xfer) out_left_q <= out_left_q - (ROM_ADDR_WIDTH+1)'(1);
         // ROM latches the address one edge after issue; OE covers the following cycle.
         pend_q <= issue;
         rom_oe <= pend_q;
         done   <= (accept && (len == '0)) || last_xfer;
      end
   end

   rom_rd_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (ROM_DATA_WIDTH)
   ) u_fifo (
      .CK    (CK),
      .RST_N (RST_N),
      .push  (rom_oe),
      .wdata (rom_q),
      .pop   (y_ready),
      .rdata (y_data),
      .valid (y_valid),
      .count (fifo_count)
   );

`ifdef ROM_Y_RD_STALL_CNT_EN
   logic [15:0] stall_q;

   always_ff @(posedge CK or negedge RST_N) begin
      if (!RST_N)                                           stall_q <= '0;
      else if (accept)                                      stall_q <= '0;
      else if (y_valid && !y_ready && (stall_q != 16'hFFFF)) stall_q <= stall_q + 16'd1;
   end

   assign stall_cnt = stall_q;
`else
   assign stall_cnt = '0;
`endif

endmodule
